// File: rtl/hazard_control_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_control_unit_pkg
//  Description : Shared widths and counter-control types for the pipeline
//                hazard control block.
//  Revision    : 1.0  initial release
// ============================================================================
package hazard_control_unit_pkg;

    // Default widths of the ARM core datapath
    localparam int ADDRESS_LEN     = 32;
    localparam int REG_ADDRESS_LEN = 4;
    localparam int PERF_CNT_LEN    = 32;

    // Per-cycle action applied to a saturating performance counter
    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_CLR  = 2'd2
    } cnt_op_t;

    // Clear wins over increment; a saturated counter holds instead of wrapping
    function automatic cnt_op_t cnt_op(
        input logic clr,
        input logic event_hit,
        input logic saturated
    );
        cnt_op_t op;
        op = CNT_HOLD;
        if (clr) begin
            op = CNT_CLR;
        end else if (event_hit && !saturated) begin
            op = CNT_INC;
        end
        return op;
    endfunction

endpackage : hazard_control_unit_pkg
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Two-slot (EX, MEM) scoreboard of in-flight register writes
//                with read-after-write comparison against the ID sources.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_scoreboard
    import hazard_control_unit_pkg::*;
#(
    parameter int REG_W = REG_ADDRESS_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic [REG_W-1:0] id_dest,
    output logic             hazard
);

    logic             ex_valid_q,  ex_valid_d;
    logic [REG_W-1:0] ex_dest_q,   ex_dest_d;
    logic             mem_valid_q, mem_valid_d;
    logic [REG_W-1:0] mem_dest_q,  mem_dest_d;
    logic             ex_hit;
    logic             mem_hit;

    // A slot matches when it is live and its dest is one of the sources read
    function automatic logic slot_hit(
        input logic             valid,
        input logic [REG_W-1:0] dest,
        input logic [REG_W-1:0] src1,
        input logic [REG_W-1:0] src2,
        input logic             two_src
    );
        return valid && ((dest == src1) || (two_src && (dest == src2)));
    endfunction

    // Shift EX into MEM every cycle; only an issued writer enters EX
    always_comb begin
        ex_valid_d  = issue;
        ex_dest_d   = issue ? id_dest : '0;
        mem_valid_d = ex_valid_q;
        mem_dest_d  = ex_dest_q;
    end

    // Slot registers; reset empties the scoreboard
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_q  <= 1'b0;
            ex_dest_q   <= '0;
            mem_valid_q <= 1'b0;
            mem_dest_q  <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_dest_q   <= ex_dest_d;
            mem_valid_q <= mem_valid_d;
            mem_dest_q  <= mem_dest_d;
        end
    end

    // Hazard if a real ID instruction reads a register still being produced
    always_comb begin
        ex_hit  = slot_hit(ex_valid_q,  ex_dest_q,  id_src1, id_src2, id_two_src);
        mem_hit = slot_hit(mem_valid_q, mem_dest_q, id_src1, id_src2, id_two_src);
        hazard  = id_valid && (ex_hit || mem_hit);
    end

endmodule : hazard_scoreboard
`default_nettype wire

// File: rtl/hazard_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_control_unit
//  Description : Pipeline control for the ARM core: RAW freeze without
//                forwarding, one-cycle branch redirect/flush, and saturating
//                stall/flush performance counters.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int ADDR_W = ADDRESS_LEN,
    parameter int REG_W  = REG_ADDRESS_LEN,
    parameter int CNT_W  = PERF_CNT_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_src1,
    input  logic [REG_W-1:0]  id_src2,
    input  logic              id_two_src,
    input  logic              id_wb_enable,
    input  logic [REG_W-1:0]  id_dest,
    input  logic              ex_branch_req,
    input  logic [ADDR_W-1:0] ex_branch_target,
    input  logic              clr_counters,
    output logic              freeze,
    output logic              flush,
    output logic              bubble,
    output logic              branch_taken,
    output logic [ADDR_W-1:0] branch_addr,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    logic             hazard;
    logic             br;
    logic             freeze_w;
    logic             flush_w;
    logic             issue;
    logic             flush_dly_q, flush_dly_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    hazard_scoreboard #(
        .REG_W (REG_W)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .issue      (issue),
        .id_valid   (id_valid),
        .id_src1    (id_src1),
        .id_src2    (id_src2),
        .id_two_src (id_two_src),
        .id_dest    (id_dest),
        .hazard     (hazard)
    );

    // Branch redirect wins over freeze; the instruction behind a flush is a
    // bubble, so a request right after a flush is ignored. All gated by reset.
    always_comb begin
        br       = rst && ex_branch_req && !flush_dly_q;
        flush_w  = br;
        freeze_w = rst && hazard && !br;
        issue    = rst && id_valid && id_wb_enable && !freeze_w && !flush_w;
    end

    // Drive the pipeline control outputs
    always_comb begin
        freeze       = freeze_w;
        flush        = flush_w;
        bubble       = freeze_w || flush_w;
        branch_taken = br;
        branch_addr  = br ? ex_branch_target : '0;
        stall_count  = stall_count_q;
        flush_count  = flush_count_q;
    end

    // Next value of the flush history bit and both saturating counters
    always_comb begin
        flush_dly_d = flush_w;

        stall_count_d = stall_count_q;
        case (cnt_op(clr_counters, freeze_w, &stall_count_q))
            CNT_CLR:  stall_count_d = '0;
            CNT_INC:  stall_count_d = stall_count_q + 1'b1;
            default:  stall_count_d = stall_count_q;
        endcase

        flush_count_d = flush_count_q;
        case (cnt_op(clr_counters, flush_w, &flush_count_q))
            CNT_CLR:  flush_count_d = '0;
            CNT_INC:  flush_count_d = flush_count_q + 1'b1;
            default:  flush_count_d = flush_count_q;
        endcase
    end

    // State registers; reset discards flush history and zeroes the counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_dly_q   <= 1'b0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            flush_dly_q   <= flush_dly_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

endmodule : hazard_control_unit
`default_nettype wire
